cache_axi_master: RTL
=====================

CACHE_AXI_MASTER -- requirements
Module: cache_axi_master

Interface
REQ-001 SHALL have parameters AXI_ADDR_WIDTH (default 32, address width), AXI_DATA_WIDTH (default 32, beat width) and BLOCK_WIDTH (default 512, cache-line width); BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH (16 at defaults).
REQ-002 SHALL have the following ports (name, direction, width, meaning); reset is arst, asynchronous, active-high; clock is clk.
- clk in 1: clock.
- arst in 1: asynchronous active-high reset.
- i_fill_req in 1: line-fill request.
- i_wb_req in 1: write-back request.
- i_addr in AXI_ADDR_WIDTH: line address; low log2(BLOCK_WIDTH/8) bits are ignored and driven to 0 on the bus.
- i_blk_data in AXI_DATA_WIDTH: current beat from the line shift buffer.
- o_blk_data out AXI_DATA_WIDTH: fill beat sent to the line shift buffer.
- o_blk_shift out 1: shift-buffer write enable.
- o_start_read out 1: fill in progress (buffer in shift mode).
- o_start_write out 1: write-back in progress (buffer in shift mode).
- o_done out 1: one-cycle completion pulse.
- o_error out 1: valid with o_done; bad response, rlast misalignment or timeout.
- AR channel: o_arvalid, i_arready, o_araddr.
- R channel: i_rvalid, o_rready, i_rdata, i_rlast, i_rresp[1:0].
- AW channel: o_awvalid, i_awready, o_awaddr.
- W channel: o_wvalid, i_wready, o_wdata, o_wlast, o_wstrb.
- B channel: i_bvalid, o_bready, i_bresp[1:0].
- o_arlen/o_awlen out 8: constant BEATS-1.
- o_arsize/o_awsize out 3: constant log2(AXI_DATA_WIDTH/8).
- o_arburst/o_awburst out 2: constant INCR (2'b01).

Function
REQ-003 SHALL implement the FSM states IDLE, AR, R, AW, W, B and DONE.
REQ-004 In IDLE, requests SHALL be sampled; i_wb_req has priority over i_fill_req when both are high; a request SHALL latch i_addr into the address register.
REQ-005 Fill path SHALL be IDLE->AR; o_arvalid SHALL hold until i_arready, then the FSM SHALL go to R.
REQ-006 In R, o_rready SHALL be 1; each i_rvalid&o_rready beat SHALL set o_blk_shift=1 and o_blk_data=i_rdata in the same cycle (combinational) and increment the beat counter.
REQ-007 The FSM SHALL leave R to DONE on beat BEATS-1.
REQ-008 Write-back path SHALL be IDLE->AW; o_awvalid SHALL hold until i_awready, then the FSM SHALL go to W; AW and W SHALL never overlap.
REQ-009 In W, o_wvalid SHALL be 1, o_wdata SHALL equal i_blk_data and o_wstrb SHALL be all ones; each o_wvalid&i_wready beat SHALL pulse o_blk_shift; o_wlast SHALL be 1 when the beat counter equals BEATS-1.
REQ-010 After the last W beat the FSM SHALL go to B; in B, o_bready SHALL be 1, and i_bvalid SHALL move the FSM to DONE.
REQ-011 o_start_read SHALL be 1 in AR, R and DONE for a fill; o_start_write SHALL be 1 in AW, W, B and DONE for a write-back; both SHALL be 0 in IDLE.
REQ-012 DONE SHALL last exactly 1 cycle with o_done=1, then return to IDLE; the line is valid on the shift buffer in that cycle.
REQ-013 Any rresp/bresp != OKAY, or i_rlast not asserted exactly on beat BEATS-1, SHALL set a sticky error flag; the burst SHALL still complete by count; o_error SHALL equal the flag in DONE; the flag SHALL clear on entry to AR/AW.
REQ-014 The beat counter SHALL be $clog2(BEATS) bits wide, SHALL clear on entry to R/W and SHALL not wrap within a burst.
REQ-015 Requests arriving outside IDLE SHALL be ignored, not queued.

Reset
REQ-016 arst SHALL force IDLE, counter 0, error flag 0 and the address register 0; all valid/ready, o_blk_shift, o_start_*, o_done and o_error SHALL be 0.
REQ-017 Reset mid-burst SHALL abandon the transaction with no o_done.

Configuration
REQ-018 With CACHE_AXI_TIMEOUT_EN defined, a 10-bit watchdog SHALL count cycles in AR/R/AW/W/B without a handshake, resetting on any handshake; at 1023 the FSM SHALL go to DONE with o_error=1.
REQ-019 Without CACHE_AXI_TIMEOUT_EN, no watchdog logic SHALL exist and the FSM SHALL wait indefinitely.

Structure
REQ-020 Package cache_axi_pkg SHALL hold the state enum, the BURST_INCR and RESP_OKAY constants, and a size-encoding function.
REQ-021 Sub-module cache_axi_watchdog SHALL be instantiated only under CACHE_AXI_TIMEOUT_EN.

Verification
REQ-022 Fill at 0x1000_0040, arready after 2 cycles, 16 rdata beats 0..15 with rlast on beat 15 -> araddr 0x1000_0040, arlen 15, 16 shifts carrying 0..15, o_done=1 with o_error=0.
REQ-023 Write-back at 0x2000_0000 with i_blk_data tracking the shift count, wready toggling every other cycle -> 16 W beats, wlast only on beat 15, B OKAY -> o_done.
REQ-024 i_wb_req and i_fill_req high together -> AW is issued first; the fill is ignored.
REQ-025 bresp=SLVERR, or rlast on beat 14 -> o_error=1 with o_done, FSM back to IDLE.
REQ-026 arst asserted mid-R at beat 7 -> all outputs 0 next edge, IDLE; a following fill works normally.
REQ-027 With CACHE_AXI_TIMEOUT_EN, awready held low -> DONE with o_error=1 after 1023 cycles.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// Shared types and encodings for the cache line-fill / write-back AXI master.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AXI AxSIZE encoding: log2 of the beat size in bytes.
  function automatic logic [2:0] size_enc(input int unsigned bytes);
    logic [2:0] enc;
    enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) enc = 3'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/cache_axi_watchdog.sv
// Stall watchdog: counts cycles in a bus phase without a handshake and
// flags a timeout once the count saturates at 1023.
module cache_axi_watchdog (
  input  logic clk,
  input  logic arst,
  input  logic active,
  input  logic handshake,
  output logic timeout
);

  logic [9:0] count_reg;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count_reg <= '0;
    end else if (!active || handshake) begin
      count_reg <= '0;
    end else if (count_reg != 10'h3FF) begin
      count_reg <= count_reg + 10'd1;
    end
  end

  assign timeout = active && !handshake && (count_reg == 10'h3FF);

endmodule

// File: rtl/cache_axi_master.sv
// Cache-line AXI master: one INCR burst per fill (AR/R) or write-back (AW/W/B).
// Optional stall watchdog enabled by defining CACHE_AXI_TIMEOUT_EN.
module cache_axi_master
  import cache_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BLOCK_WIDTH    = 512
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        i_fill_req,
  input  logic                        i_wb_req,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_blk_data,
  output logic [AXI_DATA_WIDTH-1:0]   o_blk_data,
  output logic                        o_blk_shift,
  output logic                        o_start_read,
  output logic                        o_start_write,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_arvalid,
  input  logic                        i_arready,
  output logic [AXI_ADDR_WIDTH-1:0]   o_araddr,
  output logic [7:0]                  o_arlen,
  output logic [2:0]                  o_arsize,
  output logic [1:0]                  o_arburst,
  input  logic                        i_rvalid,
  output logic                        o_rready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_rdata,
  input  logic                        i_rlast,
  input  logic [1:0]                  i_rresp,
  output logic                        o_awvalid,
  input  logic                        i_awready,
  output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
  output logic [7:0]                  o_awlen,
  output logic [2:0]                  o_awsize,
  output logic [1:0]                  o_awburst,
  output logic                        o_wvalid,
  input  logic                        i_wready,
  output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
  output logic                        o_wlast,
  output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
  input  logic                        i_bvalid,
  output logic                        o_bready,
  input  logic [1:0]                  i_bresp
);

  localparam int BEATS  = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  state_t                    state_reg, state_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic                      err_reg, err_next;
  logic                      is_wb_reg, is_wb_next;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      is_wb_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      is_wb_reg <= is_wb_next;
    end
  end

`ifdef CACHE_AXI_TIMEOUT_EN
  logic active, handshake, timeout;

  assign active = (state_reg == ST_AR) || (state_reg == ST_R) || (state_reg == ST_AW) ||
                  (state_reg == ST_W) || (state_reg == ST_B);
  assign handshake = (o_arvalid & i_arready) | (o_rready & i_rvalid) |
                     (o_awvalid & i_awready) | (o_wvalid & i_wready) |
                     (o_bready & i_bvalid);

  cache_axi_watchdog u_watchdog (
    .clk       (clk),
    .arst      (arst),
    .active    (active),
    .handshake (handshake),
    .timeout   (timeout)
  );
`endif

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    is_wb_next    = is_wb_reg;
    o_arvalid     = 1'b0;
    o_rready      = 1'b0;
    o_awvalid     = 1'b0;
    o_wvalid      = 1'b0;
    o_wlast       = 1'b0;
    o_bready      = 1'b0;
    o_blk_shift   = 1'b0;
    o_start_read  = 1'b0;
    o_start_write = 1'b0;
    o_done        = 1'b0;
    o_error       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Write-back wins so a dirty victim leaves before the new line arrives.
        if (i_wb_req || i_fill_req) begin
          addr_next  = {i_addr[AXI_ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
          err_next   = 1'b0;
          is_wb_next = i_wb_req;
          state_next = i_wb_req ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        o_arvalid    = 1'b1;
        o_start_read = 1'b1;
        if (i_arready) begin
          cnt_next   = '0;
          state_next = ST_R;
        end
      end
      ST_R: begin
        o_rready     = 1'b1;
        o_start_read = 1'b1;
        if (i_rvalid) begin
          o_blk_shift = 1'b1;
          if ((i_rresp != RESP_OKAY) || (i_rlast != (cnt_reg == LAST_BEAT))) err_next = 1'b1;
          if (cnt_reg == LAST_BEAT) state_next = ST_DONE;
          else                      cnt_next   = cnt_reg + 1'b1;
        end
      end
      ST_AW: begin
        o_awvalid     = 1'b1;
        o_start_write = 1'b1;
        if (i_awready) begin
          cnt_next   = '0;
          state_next = ST_W;
        end
      end
      ST_W: begin
        o_wvalid      = 1'b1;
        o_start_write = 1'b1;
        o_wlast       = (cnt_reg == LAST_BEAT);
        if (i_wready) begin
          o_blk_shift = 1'b1;
          if (cnt_reg == LAST_BEAT) state_next = ST_B;
          else                      cnt_next   = cnt_reg + 1'b1;
        end
      end
      ST_B: begin
        o_bready      = 1'b1;
        o_start_write = 1'b1;
        if (i_bvalid) begin
          if (i_bresp != RESP_OKAY) err_next = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done        = 1'b1;
        o_error       = err_reg;
        o_start_read  = !is_wb_reg;
        o_start_write = is_wb_reg;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
`ifdef CACHE_AXI_TIMEOUT_EN
    if (timeout) begin
      err_next   = 1'b1;
      state_next = ST_DONE;
    end
`endif
  end

  assign o_blk_data = i_rdata;
  assign o_wdata    = i_blk_data;
  assign o_wstrb    = '1;
  assign o_araddr   = addr_reg;
  assign o_awaddr   = addr_reg;
  assign o_arlen    = 8'(BEATS - 1);
  assign o_awlen    = 8'(BEATS - 1);
  assign o_arsize   = size_enc(AXI_DATA_WIDTH / 8);
  assign o_awsize   = size_enc(AXI_DATA_WIDTH / 8);
  assign o_arburst  = BURST_INCR;
  assign o_awburst  = BURST_INCR;

endmodule
